sa_mmm_ctrl: RTL and testbench

//  Sequencer for the NxN fp16 systolic array: each PE holds the fp16 multiplier and adder pair.

---
 rtl/sa_mmm_ctrl_if.sv | 62 ++++++
 rtl/sa_mmm_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sa_mmm_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_mmm_ctrl_if.sv
// Bus bundle between the tile DMA / PE grid side and the systolic-array
// sequencer. The controller uses the master modport; the environment
// (DMA, buffers, PE grid, drain consumer) uses the slave modport.
// Optional feature macro: SA_ABORT_EN adds the abort input.
interface sa_mmm_ctrl_if #(
  parameter int ARRAY_N = 4,
  parameter int K_W     = 8
);
  localparam int ROW_W = $clog2(ARRAY_N);

  logic               start;
  logic [K_W-1:0]     k_len;
  logic               busy;
  logic               done;
  logic               op_rd_en;
  logic [K_W-1:0]     op_rd_addr;
  logic               pe_clear;
  logic [ARRAY_N-1:0] row_vld;
  logic [ARRAY_N-1:0] col_vld;
  logic               out_valid;
  logic               out_ready;
  logic [ROW_W-1:0]   out_row;
`ifdef SA_ABORT_EN
  logic               abort;
`endif

  modport master (
    input  start,
    input  k_len,
    input  out_ready,
`ifdef SA_ABORT_EN
    input  abort,
`endif
    output busy,
    output done,
    output op_rd_en,
    output op_rd_addr,
    output pe_clear,
    output row_vld,
    output col_vld,
    output out_valid,
    output out_row
  );

  modport slave (
    output start,
    output k_len,
    output out_ready,
`ifdef SA_ABORT_EN
    output abort,
`endif
    input  busy,
    input  done,
    input  op_rd_en,
    input  op_rd_addr,
    input  pe_clear,
    input  row_vld,
    input  col_vld,
    input  out_valid,
    input  out_row
  );
endinterface

// File: rtl/sa_mmm_ctrl.sv
// sa_mmm_ctrl: sequencer for an NxN fp16 systolic array. One start runs one
// tile: CLEAR (zero accumulators), FEED (k_len operand reads), FLUSH (let the
// last operand wave retire in PE(N-1,N-1)), DRAIN (N result rows over
// valid/ready), DONE (one-cycle pulse). Every output is a register loaded
// from the next-state decode, so outputs line up with the state they belong to.
// Optional feature macro: SA_ABORT_EN adds an abort input that drops any
// active tile back to IDLE without a done pulse.
module sa_mmm_ctrl #(
  parameter int ARRAY_N = 4,
  parameter int K_W     = 8,
  parameter int PE_LAT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  sa_mmm_ctrl_if.master bus
);

  localparam int ROW_W     = $clog2(ARRAY_N);
  localparam int CNT_W     = $clog2(2 * ARRAY_N + PE_LAT + 1);
  // Last read needs 1 cycle of buffer latency, 2*(N-1) cycles of skew/travel
  // to reach the far corner PE, then PE_LAT cycles to retire its accumulate.
  localparam int FLUSH_LEN = 1 + 2 * (ARRAY_N - 1) + PE_LAT;

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARRAY_N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pe_clear_q, pe_clear_d;
  logic               op_rd_en_q, op_rd_en_d;
  logic [K_W-1:0]     op_rd_addr_q, op_rd_addr_d;
  logic               out_valid_q, out_valid_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic [ARRAY_N-1:0] vld_q, vld_d;
  logic               abort_s;

`ifdef SA_ABORT_EN
  // Abort only matters while a tile is active; in IDLE it is ignored.
  assign abort_s = bus.abort & (state_q != S_IDLE);
`else
  assign abort_s = 1'b0;
`endif

  // State register plus all registered outputs, counters and the skew line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= {K_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pe_clear_q   <= 1'b0;
      op_rd_en_q   <= 1'b0;
      op_rd_addr_q <= {K_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_row_q    <= {ROW_W{1'b0}};
      vld_q        <= {ARRAY_N{1'b0}};
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      flush_cnt_q  <= flush_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pe_clear_q   <= pe_clear_d;
      op_rd_en_q   <= op_rd_en_d;
      op_rd_addr_q <= op_rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      vld_q        <= vld_d;
    end
  end

  // Next-state decode; abort overrides every other input.
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.k_len != {K_W{1'b0}}) begin
              state_d = S_CLEAR;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLEAR: state_d = S_FEED;
        S_FEED: begin
          if (op_rd_addr_q == (k_q - K_W'(1))) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_FEED;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FLUSH;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready && (out_row_q == ROW_LAST)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/counter decode from the upcoming state; counters restart on entry.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    pe_clear_d  = (state_d == S_CLEAR);
    op_rd_en_d  = (state_d == S_FEED);
    out_valid_d = (state_d == S_DRAIN);

    if ((state_q == S_IDLE) && bus.start) begin
      k_d = bus.k_len;
    end else begin
      k_d = k_q;
    end

    if ((state_d == S_FEED) && (state_q == S_FEED)) begin
      op_rd_addr_d = op_rd_addr_q + K_W'(1);
    end else begin
      op_rd_addr_d = {K_W{1'b0}};
    end

    if ((state_d == S_FLUSH) && (state_q == S_FLUSH)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = {CNT_W{1'b0}};
    end

    if ((state_d == S_DRAIN) && (state_q == S_DRAIN)) begin
      if (bus.out_ready) begin
        out_row_d = out_row_q + ROW_W'(1);
      end else begin
        out_row_d = out_row_q;
      end
    end else begin
      out_row_d = {ROW_W{1'b0}};
    end

    // Bit 0 trails the read strobe by the buffer's 1-cycle latency; each
    // further row/column sees the wave one cycle later.
    if (abort_s) begin
      vld_d = {ARRAY_N{1'b0}};
    end else begin
      vld_d = {vld_q[ARRAY_N-2:0], op_rd_en_q};
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pe_clear   = pe_clear_q;
  assign bus.op_rd_en   = op_rd_en_q;
  assign bus.op_rd_addr = op_rd_addr_q;
  assign bus.row_vld    = vld_q;
  assign bus.col_vld    = vld_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_row    = out_row_q;

endmodule

// File: tb/tb_sa_mmm_ctrl.sv
// Self-checking bench for sa_mmm_ctrl. Expected per-cycle output vectors come
// from a schedule model: offsets of clear/reads/drain are computed from k_len,
// the flush length and the random ready sequence. Abort cases run only when
// SA_ABORT_EN is defined.
module tb_sa_mmm_ctrl;
  localparam int N     = 4;
  localparam int K_W   = 8;
  localparam int PE_L  = 2;
  localparam int RW    = $clog2(N);
  localparam int FL    = 1 + 2 * (N - 1) + PE_L;
  localparam int DEPTH = 512;

  logic clk;
  logic rst;

  sa_mmm_ctrl_if #(.ARRAY_N(N), .K_W(K_W)) bus ();

  sa_mmm_ctrl #(.ARRAY_N(N), .K_W(K_W), .PE_LAT(PE_L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_tiles  = 0;

  // Tile schedule model state.
  int t_k;
  int t_D;
  int t_d0;
  int t_abort;
  bit t_rdy   [DEPTH];
  bit t_valid [DEPTH];
  int t_row   [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input bit busy, input bit done, input bit clr,
                                       input bit rd, input logic [K_W-1:0] addr,
                                       input logic [N-1:0] rv, input logic [N-1:0] cv,
                                       input bit valid, input logic [RW-1:0] row);
    return 64'({busy, done, clr, rd, addr, rv, cv, valid, row});
  endfunction

  function automatic logic [63:0] obs_vec();
    return pack(bus.busy, bus.done, bus.pe_clear, bus.op_rd_en, bus.op_rd_addr,
                bus.row_vld, bus.col_vld, bus.out_valid, bus.out_row);
  endfunction

  // Reads happen at offsets 2 .. k+1 after the start cycle.
  function automatic bit model_rd(input int o);
    return (t_k > 0) && (o >= 2) && (o < t_k + 2);
  endfunction

  function automatic logic [63:0] exp_vec(input int o);
    logic [N-1:0]   v;
    logic [K_W-1:0] addr;
    bit             rd;
    if (((t_abort >= 1) && (o > t_abort)) || (o < 1) || (o > t_D)) return 64'd0;
    rd   = model_rd(o);
    addr = rd ? K_W'(o - 2) : {K_W{1'b0}};
    for (int i = 0; i < N; i++) v[i] = model_rd(o - 1 - i);
    return pack(1'b1, (o == t_D), (t_k > 0) && (o == 1), rd, addr, v, v,
                t_valid[o], RW'(t_row[o]));
  endfunction

  // Runs one tile starting in the current cycle. mode: 0 random ready,
  // 1 ready always high, 2 fixed ready pattern at drain start.
  // spur: -1 none, 0 random busy cycle, >0 fixed offset. abort_o: -1 none.
  task automatic run_tile(input int k, input int mode, input int spur, input int abort_o);
    int row;
    int o;
    int last;
    int spur_o;
    bit [6:0] pat;
    pat     = 7'b1011001;
    t_k     = k;
    t_abort = abort_o;
    t_d0    = k + 2 + FL;
    for (int i = 0; i < DEPTH; i++) begin
      t_valid[i] = 1'b0;
      t_row[i]   = 0;
      if (mode == 1 || i >= 350) t_rdy[i] = 1'b1;
      else t_rdy[i] = ($urandom_range(1, 0) == 1);
    end
    if (mode == 2) begin
      for (int i = 0; i < 7; i++) t_rdy[t_d0 + i] = pat[i];
    end
    if (k == 0) begin
      t_D = 1;
    end else begin
      row = 0;
      o   = t_d0;
      while (row < N) begin
        t_valid[o] = 1'b1;
        t_row[o]   = row;
        if (t_rdy[o]) row++;
        o++;
      end
      t_D = o;
    end
    last   = (abort_o >= 1) ? abort_o + 1 : t_D + 1;
    spur_o = (spur == 0) ? $urandom_range(t_D, 1) : spur;

    bus.start     = 1'b1;
    bus.k_len     = K_W'(k);
    bus.out_ready = t_rdy[0];
`ifdef SA_ABORT_EN
    bus.abort     = (abort_o == 0);
`endif
    for (o = 1; o <= last; o++) begin
      @(negedge clk);
      check_eq($sformatf("tile%0d_k%0d_o%0d", n_tiles, k, o), obs_vec(), exp_vec(o));
      bus.start     = (o == spur_o);
      bus.k_len     = K_W'($urandom());
      bus.out_ready = t_rdy[o];
`ifdef SA_ABORT_EN
      bus.abort     = (o == abort_o);
`endif
    end
    n_tiles++;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, obs_vec(), 64'd0);
      bus.start     = 1'b0;
      bus.out_ready = ($urandom_range(1, 0) == 1);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.out_ready = 1'b0;
`ifdef SA_ABORT_EN
    bus.abort     = 1'b0;
`endif
    @(negedge clk);
    check_eq("reset_state", obs_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2, "post_reset_idle");

    // Reference tile, k=3, ready always high: 19 cycles start..done.
    run_tile(3, 1, -1, -1);
    // Empty tile, back to back.
    run_tile(0, 0, -1, -1);
    idle_cycles(1, "idle_after_k0");
    // Drain with ready pattern 1,0,0,1,1,0,1.
    run_tile(2, 2, -1, -1);
    // Start pulsed during FEED of k=5 is ignored.
    run_tile(5, 0, 4, -1);
    // Boundary k values.
    run_tile(1, 0, -1, -1);
    run_tile(255, 0, 0, -1);

    // Async reset in the middle of FEED.
    bus.start = 1'b1;
    bus.k_len = K_W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_eq("rst_async_mid_feed", obs_vec(), 64'd0);
    @(negedge clk);
    check_eq("rst_held", obs_vec(), 64'd0);
    rst = 1'b0;
    idle_cycles(1, "idle_after_rst");
    run_tile(4, 0, -1, -1);

`ifdef SA_ABORT_EN
    // Abort while row 2 is presented on the drain port.
    run_tile(2, 1, -1, 2 + 2 + FL + 2);
    idle_cycles(1, "idle_after_abort");
    // Abort in IDLE alone does nothing.
    bus.abort = 1'b1;
    idle_cycles(2, "abort_in_idle");
    bus.abort = 1'b0;
    // Abort together with start in IDLE: tile still runs.
    run_tile(3, 0, -1, 0);
    // Abort during FEED.
    run_tile(6, 0, -1, 4);
`endif

    // Random tiles with random gaps and stray starts.
    for (int t = 0; t < 12; t++) begin
      int k;
      k = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(20, 1);
      run_tile(k, 0, ($urandom_range(1, 0) == 1) ? 0 : -1, -1);
      idle_cycles($urandom_range(2, 0), "random_gap");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
